id_ex_stage: RTL and testbench

- Decode and operand-select stage that sits directly upstream of the RV32I ALU.
- Accepts one fetched instruction plus register-file read data per handshake, decodes OP, OP-IMM, LUI and AUIPC, and builds op1/op2/alu_ctrl.
- Holds the result in a single registered pipeline slot with valid/ready flow control and flush.

---
 rtl/id_ex_stage.sv | 202 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode / operand-select stage feeding the ALU.
// Decodes OP, OP-IMM, LUI and AUIPC into op1/op2/alu_ctrl and holds the
// result in one registered slot with valid/ready flow control and flush.
// Optional feature macro: ILLEGAL_TRAP_EN. When it is defined, illegal
// instructions are passed downstream with the illegal flag set. When it is
// not defined, illegal instructions are accepted and silently dropped.
module id_ex_stage #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_TAG = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [3:0]      alu_ctrl,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
`ifdef ILLEGAL_TRAP_EN
  output logic [XLEN-1:0] out_pc,
  output logic            illegal
`else
  output logic [XLEN-1:0] out_pc
`endif
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

`ifdef ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [6:0]      funct7_s;
  logic [XLEN-1:0] imm_i_s;
  logic [XLEN-1:0] imm_u_s;
  logic [XLEN-1:0] shamt_s;
  logic            legal_s;
  logic [XLEN-1:0] raw_op1_s;
  logic [XLEN-1:0] raw_op2_s;
  logic [3:0]      raw_ctrl_s;
  logic [XLEN-1:0] dec_op1_s;
  logic [XLEN-1:0] dec_op2_s;
  logic [3:0]      dec_ctrl_s;
  logic            dec_we_s;
  logic            xfer_s;
  logic            load_s;

  logic            out_valid_r;
  logic [XLEN-1:0] op1_r;
  logic [XLEN-1:0] op2_r;
  logic [3:0]      alu_ctrl_r;
  logic [4:0]      rd_addr_r;
  logic            rd_we_r;
  logic [XLEN-1:0] out_pc_r;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];
  assign imm_i_s  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u_s  = {instr[31:12], 12'h000};
  assign shamt_s  = {27'd0, instr[24:20]};

  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  // Instruction decode: operands, ALU code and legality from the raw word
  always_comb begin
    legal_s    = 1'b0;
    raw_op1_s  = 32'h0000_0000;
    raw_op2_s  = 32'h0000_0000;
    raw_ctrl_s = 4'b0000;
    case (opcode_s)
      OPC_OP: begin
        raw_op1_s  = rs1_data;
        raw_op2_s  = rs2_data;
        raw_ctrl_s = {instr[30], funct3_s};
        if (funct7_s == 7'h00) begin
          legal_s = 1'b1;
        end else if (funct7_s == 7'h20) begin
          legal_s = (funct3_s == 3'b000) || (funct3_s == 3'b101);
        end else begin
          legal_s = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        raw_op1_s = rs1_data;
        case (funct3_s)
          3'b001: begin
            raw_op2_s  = shamt_s;
            raw_ctrl_s = 4'b0001;
            legal_s    = (funct7_s == 7'h00);
          end
          3'b101: begin
            raw_op2_s  = shamt_s;
            raw_ctrl_s = {instr[30], 3'b101};
            legal_s    = (funct7_s == 7'h00) || (funct7_s == 7'h20);
          end
          default: begin
            raw_op2_s  = imm_i_s;
            raw_ctrl_s = {1'b0, funct3_s};
            legal_s    = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        raw_op1_s  = 32'h0000_0000;
        raw_op2_s  = imm_u_s;
        raw_ctrl_s = 4'b0000;
        legal_s    = 1'b1;
      end
      OPC_AUIPC: begin
        raw_op1_s  = pc;
        raw_op2_s  = imm_u_s;
        raw_ctrl_s = 4'b0000;
        legal_s    = 1'b1;
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
  end

  // Illegal instructions carry neutral fields so a trapping consumer sees no side effects
  assign dec_op1_s  = legal_s ? raw_op1_s  : 32'h0000_0000;
  assign dec_op2_s  = legal_s ? raw_op2_s  : 32'h0000_0000;
  assign dec_ctrl_s = legal_s ? raw_ctrl_s : 4'b0000;
  assign dec_we_s   = legal_s && (instr[11:7] != 5'd0);

  assign in_ready = !out_valid_r || out_ready;
  assign xfer_s   = in_valid && in_ready;
  assign load_s   = xfer_s && (legal_s || TRAP_EN);

  // Pipeline slot: flush kills, a kept transfer loads, a lone consume empties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      op1_r       <= 32'h0000_0000;
      op2_r       <= 32'h0000_0000;
      alu_ctrl_r  <= 4'b0000;
      rd_addr_r   <= 5'd0;
      rd_we_r     <= 1'b0;
      out_pc_r    <= RESET_PC_TAG;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      op1_r       <= dec_op1_s;
      op2_r       <= dec_op2_s;
      alu_ctrl_r  <= dec_ctrl_s;
      rd_addr_r   <= instr[11:7];
      rd_we_r     <= dec_we_s;
      out_pc_r    <= pc;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_r;

  // Illegal flag travels with the rest of the slot contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_r <= 1'b0;
    end else if (!flush && load_s) begin
      illegal_r <= !legal_s;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  assign illegal = illegal_r;
`endif

  assign out_valid = out_valid_r;
  assign op1       = op1_r;
  assign op2       = op2_r;
  assign alu_ctrl  = alu_ctrl_r;
  assign rd_addr   = rd_addr_r;
  assign rd_we     = rd_we_r;
  assign out_pc    = out_pc_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed steps followed by random
// traffic, all compared against a behavioural slot/decode model.
module tb_id_ex_stage;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic [31:0] out_pc;
  logic        illegal_o;

  int total = 0;
  int bad   = 0;

  // reference model of the output slot
  logic        m_valid;
  logic [31:0] m_op1, m_op2, m_pc;
  logic [3:0]  m_ctrl;
  logic [4:0]  m_rd;
  logic        m_we, m_ill;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2),
    .alu_ctrl(alu_ctrl), .rd_addr(rd_addr), .rd_we(rd_we),
`ifdef ILLEGAL_TRAP_EN
    .out_pc(out_pc), .illegal(illegal_o)
`else
    .out_pc(out_pc)
`endif
  );

`ifndef ILLEGAL_TRAP_EN
  assign illegal_o = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Decode straight from the ISA rules using integer field values
  function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output bit ok, output logic [31:0] o1,
                                     output logic [31:0] o2, output logic [3:0] c);
    int opc, f3, f7, imm, sh_amt;
    bit sh;
    opc = int'(ins[6:0]);
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    sh_amt = int'(ins[24:20]);
    imm = int'(ins[31:20]);
    if (imm >= 2048) imm = imm - 4096;
    ok = 1'b0; o1 = 32'd0; o2 = 32'd0; c = 4'd0;
    if (opc == 32'h33) begin
      ok = (f7 == 0) || (f7 == 32'h20 && (f3 == 0 || f3 == 5));
      o1 = a; o2 = b;
      c  = 4'((f7 == 32'h20) ? 8 + f3 : f3);
    end else if (opc == 32'h13) begin
      sh = (f3 == 1) || (f3 == 5);
      ok = !sh || (f7 == 0) || (f3 == 5 && f7 == 32'h20);
      o1 = a;
      o2 = sh ? 32'(sh_amt) : 32'(imm);
      c  = 4'((f3 == 5 && f7 == 32'h20) ? 8 + f3 : f3);
    end else if (opc == 32'h37) begin
      ok = 1'b1; o1 = 32'd0; o2 = ins & 32'hFFFF_F000;
    end else if (opc == 32'h17) begin
      ok = 1'b1; o1 = pcv; o2 = ins & 32'hFFFF_F000;
    end
    if (!ok) begin
      o1 = 32'd0; o2 = 32'd0; c = 4'd0;
    end
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_op1 = 32'd0; m_op2 = 32'd0; m_ctrl = 4'd0;
    m_rd = 5'd0; m_we = 1'b0; m_pc = RST_PC; m_ill = 1'b0;
  endtask

  task automatic check_outs(input string ph);
    chk({ph, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({ph, ".op1"}, op1, m_op1);
    chk({ph, ".op2"}, op2, m_op2);
    chk({ph, ".alu_ctrl"}, 32'(alu_ctrl), 32'(m_ctrl));
    chk({ph, ".rd_addr"}, 32'(rd_addr), 32'(m_rd));
    chk({ph, ".rd_we"}, 32'(rd_we), 32'(m_we));
    chk({ph, ".out_pc"}, out_pc, m_pc);
    if (TRAP) chk({ph, ".illegal"}, 32'(illegal_o), 32'(m_ill));
  endtask

  // One clock of traffic: drive, check combinational outputs, advance model, check slot
  task automatic step(input string ph, input logic v, input logic [31:0] i,
                      input logic [31:0] p, input logic [31:0] d1, input logic [31:0] d2,
                      input logic fl, input logic ordy);
    bit ok, rdy;
    logic [31:0] e1, e2;
    logic [3:0] ec;
    in_valid = v; instr = i; pc = p; rs1_data = d1; rs2_data = d2;
    flush = fl; out_ready = ordy;
    #1;
    rdy = !m_valid || ordy;
    chk({ph, ".in_ready"}, 32'(in_ready), 32'(rdy));
    chk({ph, ".rs1_addr"}, 32'(rs1_addr), 32'(i[19:15]));
    chk({ph, ".rs2_addr"}, 32'(rs2_addr), 32'(i[24:20]));
    ref_decode(i, p, d1, d2, ok, e1, e2, ec);
    if (fl) begin
      m_valid = 1'b0;
    end else if (v && rdy && (ok || TRAP)) begin
      m_valid = 1'b1; m_op1 = e1; m_op2 = e2; m_ctrl = ec; m_rd = i[11:7];
      m_we = ok && (i[11:7] != 5'd0); m_pc = p; m_ill = !ok;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outs(ph);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1, 2: w[6:0] = 7'h33;
      3, 4, 5: w[6:0] = 7'h13;
      6:       w[6:0] = 7'h37;
      7:       w[6:0] = 7'h17;
      default: w[6:0] = 7'($urandom);
    endcase
    sel = $urandom_range(0, 3);
    if (sel == 0) w[31:25] = 7'h00;
    else if (sel == 1) w[31:25] = 7'h20;
    return w;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = 32'd0; pc = 32'd0;
    rs1_data = 32'd0; rs2_data = 32'd0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    #1;
    check_outs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // add x3,x1,x2
    step("add", 1'b1, 32'h0020_81B3, 32'h0000_0040, 32'd5, 32'd7, 1'b0, 1'b1);
    chk("add.op1c", op1, 32'd5);
    chk("add.op2c", op2, 32'd7);
    chk("add.ctrlc", 32'(alu_ctrl), 32'h0);
    chk("add.rdc", 32'(rd_addr), 32'd3);
    chk("add.wec", 32'(rd_we), 32'd1);

    step("srai", 1'b1, 32'h4030_D093, 32'h0000_0044, 32'hF000_0010, 32'd9, 1'b0, 1'b1);
    chk("srai.op2c", op2, 32'd3);
    chk("srai.ctrlc", 32'(alu_ctrl), 32'hD);

    step("addi", 1'b1, 32'hFFF0_0113, 32'h0000_0048, 32'd0, 32'd1, 1'b0, 1'b1);
    chk("addi.op1c", op1, 32'd0);
    chk("addi.op2c", op2, 32'hFFFF_FFFF);

    step("lui", 1'b1, 32'h1234_5037, 32'h0000_004C, 32'd11, 32'd12, 1'b0, 1'b1);
    chk("lui.op2c", op2, 32'h1234_5000);
    chk("lui.wec", 32'(rd_we), 32'd0);

    // auipc x5,1
    step("auipc", 1'b1, 32'h0000_1297, 32'h0000_0100, 32'd3, 32'd4, 1'b0, 1'b1);
    chk("auipc.op1c", op1, 32'h0000_0100);
    chk("auipc.ctrlc", 32'(alu_ctrl), 32'h0);

    // backpressure: hold sub x4,x1,x2 for three cycles
    step("bp_load", 1'b1, 32'h4020_8233, 32'h0000_0200, 32'd20, 32'd6, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step("bp_hold", 1'b1, 32'h0020_81B3, 32'h0000_0204, 32'd1, 32'd1, 1'b0, 1'b0);
      chk("bp.in_readyc", 32'(in_ready), 32'd0);
      chk("bp.op1c", op1, 32'd20);
      chk("bp.ctrlc", 32'(alu_ctrl), 32'h8);
    end
    step("b2b", 1'b1, 32'h0020_81B3, 32'h0000_0204, 32'd1, 32'd2, 1'b0, 1'b1);
    chk("b2b.validc", 32'(out_valid), 32'd1);
    chk("b2b.pcc", out_pc, 32'h0000_0204);

    // flush with a slot full and an accepted incoming instruction
    step("flush", 1'b1, 32'h0030_8213, 32'h0000_0208, 32'd1, 32'd2, 1'b1, 1'b1);
    chk("flush.validc", 32'(out_valid), 32'd0);

    // reset in the middle of a stall
    step("rs_load", 1'b1, 32'h0020_81B3, 32'h0000_0300, 32'd8, 32'd9, 1'b0, 1'b1);
    step("rs_stall", 1'b0, 32'h0000_0000, 32'h0000_0000, 32'd0, 32'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outs("midrst");
    @(posedge clk);
    #1 rst = 1'b0;

    // ecall is illegal
    step("ecall", 1'b1, 32'h0000_0073, 32'h0000_0400, 32'd1, 32'd2, 1'b0, 1'b1);
    chk("ecall.validc", 32'(out_valid), 32'(TRAP));
    chk("ecall.wec", 32'(rd_we), 32'd0);
    if (TRAP) chk("ecall.illc", 32'(illegal_o), 32'd1);
    step("ecall2", 1'b1, 32'h0000_0073, 32'h0000_0404, 32'd1, 32'd2, 1'b0, 1'b0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom, $urandom,
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
